// File: rtl/rtmq_resume_arbiter.sv
// Round-robin arbiter that shares the flow controller's single RESUME input among several
// hold-based peripherals, with per-grant HLD handshake, optional timeout and sticky errors.
module rtmq_resume_arbiter #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned W_ID  = $clog2(N_SRC),
  parameter int unsigned W_TMO = 16,
  parameter int unsigned TMO   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_hld,
  input  logic [N_SRC-1:0] req,
  input  logic             clr,
  input  logic             err_clr,
  output logic             f_rsm,
  output logic [N_SRC-1:0] ack,
  output logic [W_ID-1:0]  grant_id,
  output logic             busy,
  output logic [N_SRC-1:0] pend,
  output logic [1:0]       err
);

  localparam bit               TmoEn   = (TMO != 0);
  localparam logic [W_TMO-1:0] TmoLast = TmoEn ? W_TMO'(TMO - 1) : '0;

  typedef enum logic [1:0] {StIdle, StArm, StGap} state_e;

  state_e             state_q, state_d;
  logic               f_rsm_q, f_rsm_d;
  logic [N_SRC-1:0]   ack_q, ack_d;
  logic [W_ID-1:0]    grant_id_q, grant_id_d;
  logic [W_ID-1:0]    ptr_q, ptr_d;
  logic               busy_q, busy_d;
  logic [N_SRC-1:0]   pend_q, pend_d;
  logic [1:0]         err_q, err_d;
  logic [W_TMO-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic [N_SRC-1:0]   pend_clr;
  logic [1:0]         err_set;
  logic               done;
  logic               win_found;
  logic [W_ID-1:0]    win_id;
  logic [W_ID-1:0]    cand;

  // (base + off) mod N_SRC, with both operands already below N_SRC.
  function automatic logic [W_ID-1:0] wrap_add(input logic [W_ID-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_SRC) s = s - N_SRC;
    return W_ID'(s);
  endfunction

  // First pending source at or after the round-robin pointer.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      cand = wrap_add(ptr_q, k);
      if (!win_found && pend_q[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    f_rsm_d    = f_rsm_q;
    ack_d      = '0;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    busy_d     = busy_q;
    tmo_cnt_d  = tmo_cnt_q;
    pend_clr   = '0;
    err_set    = '0;
    done       = 1'b0;

    case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d    = StArm;
          grant_id_d = win_id;
          f_rsm_d    = 1'b1;
          busy_d     = 1'b1;
          tmo_cnt_d  = '0;
        end
      end
      StArm: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (f_hld) begin
          ack_d[grant_id_q] = 1'b1;
          done              = 1'b1;
        end else if (TmoEn && (tmo_cnt_q == TmoLast)) begin
          err_set[0] = 1'b1;
          done       = 1'b1;
        end
        if (done) begin
          pend_clr[grant_id_q] = 1'b1;
          ptr_d                = wrap_add(grant_id_q, 1);
          state_d              = StGap;
          f_rsm_d              = 1'b0;
        end
      end
      StGap: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        f_rsm_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // A new event on the clearing edge survives and is not a merge.
    err_set[1] = |(req & pend_q & ~pend_clr);
    pend_d     = (pend_q & ~pend_clr) | req;

    if (clr) begin
      state_d    = StIdle;
      f_rsm_d    = 1'b0;
      ack_d      = '0;
      busy_d     = 1'b0;
      pend_d     = '0;
      err_set    = '0;
      ptr_d      = ptr_q;
      grant_id_d = grant_id_q;
    end

    err_d = (err_q & ~{2{err_clr}}) | err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      f_rsm_q    <= 1'b0;
      ack_q      <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      pend_q     <= '0;
      err_q      <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      f_rsm_q    <= f_rsm_d;
      ack_q      <= ack_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign f_rsm    = f_rsm_q;
  assign ack      = ack_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign pend     = pend_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rtmq_resume_arbiter.sv
// Scoreboard bench: stimulus queues the expected end of each grant, monitors pop on f_rsm fall.
module tb_rtmq_resume_arbiter;

  typedef struct packed {
    logic [3:0] ack;
    logic [1:0] id;
    logic [7:0] len;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       f_hld0, clr0, err_clr0, f_rsm0, busy0;
  logic [3:0] req0, ack0, pend0;
  logic [1:0] gid0, err0;
  logic       f_hld1, clr1, err_clr1, f_rsm1, busy1;
  logic [3:0] req1, ack1, pend1;
  logic [1:0] gid1, err1;

  int   checks = 0;
  int   errors = 0;
  int   run0   = 0;
  int   run1   = 0;
  exp_t q0[$];
  exp_t q1[$];

  rtmq_resume_arbiter #(.N_SRC(4), .W_TMO(16), .TMO(0)) dut (
    .clk(clk), .rst_n(rst_n), .f_hld(f_hld0), .req(req0), .clr(clr0), .err_clr(err_clr0),
    .f_rsm(f_rsm0), .ack(ack0), .grant_id(gid0), .busy(busy0), .pend(pend0), .err(err0)
  );

  rtmq_resume_arbiter #(.N_SRC(4), .W_TMO(16), .TMO(10)) dut_tmo (
    .clk(clk), .rst_n(rst_n), .f_hld(f_hld1), .req(req1), .clr(clr1), .err_clr(err_clr1),
    .f_rsm(f_rsm1), .ack(ack1), .grant_id(gid1), .busy(busy1), .pend(pend1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_grant(input int inst, input logic [3:0] a, input logic [1:0] g,
                              input logic [7:0] l);
    exp_t e;
    e.ack = a;
    e.id  = g;
    e.len = l;
    if (inst == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic grant_end(input int inst, input logic [3:0] a, input logic [1:0] g,
                           input int len);
    exp_t e;
    checks++;
    if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL grant%0d unexpected: ack=%b id=%0d len=%0d", inst, a, g, len);
      return;
    end
    if (inst == 0) e = q0.pop_front();
    else e = q1.pop_front();
    if (a !== e.ack || g !== e.id || len != int'(e.len)) begin
      errors++;
      $display("FAIL grant%0d: ack=%b id=%0d len=%0d expected ack=%b id=%0d len=%0d",
               inst, a, g, len, e.ack, e.id, e.len);
    end
  endtask

  task automatic stray_ack(input int inst, input logic [3:0] a);
    checks++;
    errors++;
    $display("FAIL stray_ack%0d: got ack=%b expected 0000", inst, a);
  endtask

  // Monitor: a grant ends on the first low f_rsm sample after a run of high samples.
  always @(negedge clk) begin
    if (!rst_n) begin
      run0 = 0;
      run1 = 0;
    end else begin
      if (ack0 != 4'b0 && (f_rsm0 || run0 == 0)) stray_ack(0, ack0);
      if (f_rsm0) run0++;
      else if (run0 != 0) begin
        grant_end(0, ack0, gid0, run0);
        run0 = 0;
      end
      if (ack1 != 4'b0 && (f_rsm1 || run1 == 0)) stray_ack(1, ack1);
      if (f_rsm1) run1++;
      else if (run1 != 0) begin
        grant_end(1, ack1, gid1, run1);
        run1 = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    f_hld0 = 1'b0; clr0 = 1'b0; err_clr0 = 1'b0; req0 = '0;
    f_hld1 = 1'b0; clr1 = 1'b0; err_clr1 = 1'b0; req1 = '0;
    repeat (2) tick();
    chk("rst_f_rsm", f_rsm0, 0);
    chk("rst_ack", ack0, 0);
    chk("rst_gid", gid0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_pend", pend0, 0);
    chk("rst_err", err0, 0);
    chk("rst_f_rsm_tmo", f_rsm1, 0);
    rst_n = 1'b1;

    // Single request: req[2] at e0, f_hld at e5.
    expect_grant(0, 4'b0100, 2'd2, 8'd4);
    req0 = 4'b0100; tick(); req0 = '0;
    chk("single_pend", pend0, 4'b0100);
    chk("single_rsm_lat", f_rsm0, 0);
    tick();
    chk("single_rsm", f_rsm0, 1);
    chk("single_gid", gid0, 2);
    chk("single_busy", busy0, 1);
    repeat (3) tick();
    f_hld0 = 1'b1; tick(); f_hld0 = 1'b0;
    chk("single_ack", ack0, 4'b0100);
    chk("single_pend_clr", pend0, 0);
    chk("single_rsm_low", f_rsm0, 0);
    tick();
    chk("single_ack_pulse", ack0, 0);
    repeat (2) tick();

    // Round robin from a fresh pointer.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    expect_grant(0, 4'b0001, 2'd0, 8'd1);
    expect_grant(0, 4'b0010, 2'd1, 8'd1);
    expect_grant(0, 4'b0100, 2'd2, 8'd1);
    expect_grant(0, 4'b1000, 2'd3, 8'd1);
    f_hld0 = 1'b1;
    req0 = 4'b1111; tick(); req0 = '0;
    chk("rr_pend", pend0, 4'b1111);
    repeat (13) tick();
    expect_grant(0, 4'b0001, 2'd0, 8'd1);
    expect_grant(0, 4'b0010, 2'd1, 8'd1);
    req0 = 4'b0011; tick(); req0 = '0;
    repeat (7) tick();
    f_hld0 = 1'b0;
    chk("rr_pend_empty", pend0, 0);

    // Belated hold: 40 cycles of resume before HLD.
    expect_grant(0, 4'b1000, 2'd3, 8'd40);
    req0 = 4'b1000; tick(); req0 = '0;
    repeat (40) tick();
    f_hld0 = 1'b1; tick(); f_hld0 = 1'b0;
    chk("belated_ack", ack0, 4'b1000);
    chk("belated_err", err0, 0);
    repeat (2) tick();

    // Merge: req[1] repeated while pending.
    expect_grant(0, 4'b0010, 2'd1, 8'd2);
    req0 = 4'b0010; tick(); tick(); req0 = '0;
    chk("merge_err", err0, 2'b10);
    tick();
    f_hld0 = 1'b1; tick(); f_hld0 = 1'b0;
    chk("merge_ack", ack0, 4'b0010);
    chk("merge_pend", pend0, 0);
    err_clr0 = 1'b1; tick(); err_clr0 = 1'b0;
    chk("merge_err_clr", err0, 0);
    repeat (2) tick();

    // Set wins over clear on the acknowledging edge.
    expect_grant(0, 4'b0010, 2'd1, 8'd1);
    expect_grant(0, 4'b0010, 2'd1, 8'd1);
    req0 = 4'b0010; tick(); req0 = '0;
    tick();
    f_hld0 = 1'b1; req0 = 4'b0010; tick(); req0 = '0;
    chk("setwin_pend", pend0, 4'b0010);
    chk("setwin_err", err0, 0);
    chk("setwin_ack1", ack0, 4'b0010);
    repeat (3) tick();
    chk("setwin_ack2", ack0, 4'b0010);
    f_hld0 = 1'b0;
    repeat (2) tick();

    // Flush during ARM; a same-edge request is discarded.
    expect_grant(0, 4'b0000, 2'd2, 8'd2);
    req0 = 4'b0101; tick(); req0 = '0;
    repeat (2) tick();
    clr0 = 1'b1; req0 = 4'b1000; tick(); clr0 = 1'b0; req0 = '0;
    chk("clr_rsm", f_rsm0, 0);
    chk("clr_pend", pend0, 0);
    chk("clr_ack", ack0, 0);
    chk("clr_busy", busy0, 0);
    repeat (3) tick();
    chk("clr_stays_idle", f_rsm0, 0);

    // Timeout instance: source 0 times out, source 1 follows after GAP.
    expect_grant(1, 4'b0000, 2'd0, 8'd10);
    expect_grant(1, 4'b0010, 2'd1, 8'd1);
    req1 = 4'b0011; tick(); req1 = '0;
    repeat (11) tick();
    chk("tmo_err", err1, 2'b01);
    chk("tmo_rsm", f_rsm1, 0);
    chk("tmo_ack", ack1, 0);
    chk("tmo_pend", pend1, 4'b0010);
    chk("tmo_busy_gap", busy1, 1);
    repeat (2) tick();
    chk("tmo_next_rsm", f_rsm1, 1);
    chk("tmo_next_gid", gid1, 1);
    f_hld1 = 1'b1; tick(); f_hld1 = 1'b0;
    chk("tmo_next_ack", ack1, 4'b0010);
    err_clr1 = 1'b1; tick(); err_clr1 = 1'b0;
    chk("tmo_err_clr", err1, 0);
    repeat (2) tick();

    // Asynchronous reset mid-ARM with a merge error latched.
    req0 = 4'b0100; tick(); tick(); req0 = '0;
    chk("arst_pre_rsm", f_rsm0, 1);
    chk("arst_pre_gid", gid0, 2);
    chk("arst_pre_err", err0, 2'b10);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rsm", f_rsm0, 0);
    chk("arst_ack", ack0, 0);
    chk("arst_gid", gid0, 0);
    chk("arst_busy", busy0, 0);
    chk("arst_pend", pend0, 0);
    chk("arst_err", err0, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    chk("sb_left0", q0.size(), 0);
    chk("sb_left1", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
